// File: rtl/mem_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_arbiter_pkg
// Description : Shared types and constants for the round-robin RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_t;

  localparam int c_def_n_req  = 4;
  localparam int c_def_aw     = 8;
  localparam int c_def_dw     = 8;
  localparam int c_def_rd_lat = 1;

  // Bit positions inside a core's Mem_Ctrl bus
  localparam int c_mc_drd = 0;
  localparam int c_mc_dwr = 1;
  localparam int c_mc_ird = 2;
  localparam int c_mc_iwr = 3;

  // Wide enough for RD_LAT-1 with RD_LAT up to 3
  localparam int c_cnt_w = 2;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_arbiter_rr_picker
// Description : Combinational round-robin search starting after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter_rr_picker
  import mem_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = c_def_n_req,
  parameter int PW    = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  logic [PW-1:0] w_cand;

  // Scan farthest-first so the nearest hit after ptr is the last one written.
  always_comb begin
    idx    = '0;
    valid  = 1'b0;
    w_cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = PW'((int'(ptr) + k) % N_REQ);
      if (req[w_cand]) begin
        idx   = w_cand;
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_arbiter
// Description : Round-robin sequencer sharing one single-port sync RAM
//               between N_REQ cores, one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int N_REQ  = c_def_n_req,
  parameter int AW     = c_def_aw,
  parameter int DW     = c_def_dw,
  parameter int RD_LAT = c_def_rd_lat
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    rden,
  input  logic [N_REQ-1:0]    wren,
  input  logic [N_REQ*AW-1:0] Address,
  input  logic [N_REQ*DW-1:0] Din,
  input  logic [DW-1:0]       RAMq,
  output logic [N_REQ-1:0]    acq,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ*DW-1:0] Dq,
  output logic [AW-1:0]       RAMAddress,
  output logic [DW-1:0]       RAMDin,
  output logic                RAMwren,
  output logic                busy
);

  localparam int c_pw     = clog2_min1(N_REQ);
  localparam int c_rd_lat = (RD_LAT < 1) ? 1 : ((RD_LAT > 3) ? 3 : RD_LAT);

  arb_state_t          r_state, w_state_nxt;
  logic [c_pw-1:0]     r_ptr, w_ptr_nxt;
  logic [c_pw-1:0]     r_g, w_g_nxt;
  logic                r_op_wr, w_op_wr_nxt;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0]    r_acq, w_acq_nxt;
  logic [N_REQ-1:0]    r_ack, w_ack_nxt;
  logic [N_REQ*DW-1:0] r_dq, w_dq_nxt;
  logic [AW-1:0]       r_ram_addr, w_ram_addr_nxt;
  logic [DW-1:0]       r_ram_din, w_ram_din_nxt;
  logic                r_ram_wren, w_ram_wren_nxt;

  logic [N_REQ-1:0]    w_req;
  logic [c_pw-1:0]     w_pick_idx;
  logic                w_pick_valid;
  logic [N_REQ-1:0]    w_pick_1h;

  assign w_req     = rden | wren;
  assign w_pick_1h = N_REQ'(1) << w_pick_idx;

  mem_rr_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .PW    (c_pw)
  ) u_picker (
    .req   (w_req),
    .ptr   (r_ptr),
    .idx   (w_pick_idx),
    .valid (w_pick_valid)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_g_nxt        = r_g;
    w_op_wr_nxt    = r_op_wr;
    w_cnt_nxt      = r_cnt;
    w_acq_nxt      = r_acq;
    w_ack_nxt      = r_ack;
    w_dq_nxt       = r_dq;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_din_nxt  = r_ram_din;
    w_ram_wren_nxt = r_ram_wren;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          // A write wins when a core raises rden and wren together.
          w_g_nxt        = w_pick_idx;
          w_op_wr_nxt    = wren[w_pick_idx];
          w_ram_addr_nxt = Address[int'(w_pick_idx)*AW +: AW];
          w_ram_din_nxt  = Din[int'(w_pick_idx)*DW +: DW];
          w_ram_wren_nxt = wren[w_pick_idx];
          w_acq_nxt      = w_pick_1h;
          w_state_nxt    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        w_ram_wren_nxt = 1'b0;
        if (r_op_wr) begin
          w_ack_nxt   = r_acq;
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt   = c_cnt_w'(c_rd_lat - 1);
          w_state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_dq_nxt[int'(r_g)*DW +: DW] = RAMq;
          w_ack_nxt                    = r_acq;
          w_state_nxt                  = ST_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      ST_ACK: begin
        // The served core drops to lowest priority for the next pick.
        w_acq_nxt   = '0;
        w_ack_nxt   = '0;
        w_ptr_nxt   = r_g;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= c_pw'(N_REQ - 1);
      r_g        <= '0;
      r_op_wr    <= 1'b0;
      r_cnt      <= '0;
      r_acq      <= '0;
      r_ack      <= '0;
      r_dq       <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_wren <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_g        <= w_g_nxt;
      r_op_wr    <= w_op_wr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_acq      <= w_acq_nxt;
      r_ack      <= w_ack_nxt;
      r_dq       <= w_dq_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_din  <= w_ram_din_nxt;
      r_ram_wren <= w_ram_wren_nxt;
    end
  end

  assign acq        = r_acq;
  assign ack        = r_ack;
  assign Dq         = r_dq;
  assign RAMAddress = r_ram_addr;
  assign RAMDin     = r_ram_din;
  assign RAMwren    = r_ram_wren;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_rr_arbiter
// Description : Self-checking bench for mem_rr_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_rr_arbiter;

  localparam int N_REQ  = 4;
  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    rden, wren;
  logic [N_REQ*AW-1:0] Address;
  logic [N_REQ*DW-1:0] Din;
  logic [DW-1:0]       RAMq;
  logic [N_REQ-1:0]    acq, ack;
  logic [N_REQ*DW-1:0] Dq;
  logic [AW-1:0]       RAMAddress;
  logic [DW-1:0]       RAMDin;
  logic                RAMwren;
  logic                busy;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .rden(rden), .wren(wren), .Address(Address), .Din(Din),
    .RAMq(RAMq), .acq(acq), .ack(ack), .Dq(Dq), .RAMAddress(RAMAddress),
    .RAMDin(RAMDin), .RAMwren(RAMwren), .busy(busy)
  );

  // Single-port synchronous RAM with RD_LAT-cycle read pipeline
  logic          ram_clear;
  logic [DW-1:0] ram_mem [2**AW];
  logic [DW-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int k = 0; k < 2**AW; k++) ram_mem[k] <= '0;
    end else if (RAMwren) begin
      ram_mem[RAMAddress] <= RAMDin;
    end
    rd_pipe[0] <= ram_mem[RAMAddress];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign RAMq = rd_pipe[RD_LAT-1];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: one transaction in flight, counted in cycles since grant
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] exp_dq  [N_REQ];
  bit            m_active;
  int            m_cnt, m_g, m_last;
  bit            m_wr;
  logic [AW-1:0] m_addr, exp_addr;
  logic [DW-1:0] m_din, exp_din;
  bit            hold [N_REQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ack_at();
    return m_wr ? 2 : 2 + RD_LAT;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_cnt    = 0;
    m_g      = 0;
    m_wr     = 1'b0;
    m_last   = N_REQ - 1;
    exp_addr = '0;
    exp_din  = '0;
    for (int i = 0; i < N_REQ; i++) exp_dq[i] = '0;
  endtask

  task automatic model_edge();
    int pick;
    pick = -1;
    if (!m_active) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (pick < 0 && (rden[(m_last + k) % N_REQ] || wren[(m_last + k) % N_REQ]))
          pick = (m_last + k) % N_REQ;
      end
      if (pick >= 0) begin
        m_active = 1'b1;
        m_cnt    = 1;
        m_g      = pick;
        m_wr     = wren[pick];
        m_addr   = Address[pick*AW +: AW];
        m_din    = Din[pick*DW +: DW];
        exp_addr = m_addr;
        exp_din  = m_din;
      end
    end else begin
      m_cnt++;
      if (m_wr && m_cnt == 2) ref_mem[m_addr] = m_din;
      if (!m_wr && m_cnt == ack_at()) exp_dq[m_g] = ref_mem[m_addr];
      if (m_cnt > ack_at()) begin
        m_active = 1'b0;
        m_last   = m_g;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [N_REQ-1:0]    e_acq, e_ack;
    logic [N_REQ*DW-1:0] e_dq;
    e_acq = m_active ? (N_REQ'(1) << m_g) : '0;
    e_ack = (m_active && m_cnt == ack_at()) ? e_acq : '0;
    for (int i = 0; i < N_REQ; i++) e_dq[i*DW +: DW] = exp_dq[i];
    chk({tag, ".acq"},     64'(acq),        64'(e_acq));
    chk({tag, ".ack"},     64'(ack),        64'(e_ack));
    chk({tag, ".RAMwren"}, 64'(RAMwren),    64'(m_active && m_wr && m_cnt == 1));
    chk({tag, ".busy"},    64'(busy),       64'(m_active));
    chk({tag, ".RAMAddr"}, 64'(RAMAddress), 64'(exp_addr));
    chk({tag, ".RAMDin"},  64'(RAMDin),     64'(exp_din));
    chk({tag, ".Dq"},      64'(Dq),         64'(e_dq));
    chk({tag, ".acq1hot"}, 64'($onehot0(acq)), 64'(1));
    chk({tag, ".ackacq"},  64'(ack & ~acq), 64'(0));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_edge();
    #1;
    cyc++;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(tag);
      if (!m_active) done = 1'b1;
    end
    chk({tag, ".drained"}, 64'(done), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_idx [$];
    int ack_cyc [$];
    int exp_order [5];
    bit seen;
    int op;

    // 1. asynchronous reset with random inputs, checked before any clock edge
    rst = 1'b1;
    ram_clear = 1'b1;
    rden = N_REQ'($urandom);
    wren = N_REQ'($urandom);
    Address = N_REQ*AW'($urandom);
    Din = N_REQ*DW'($urandom);
    for (int a = 0; a < 2**AW; a++) ref_mem[a] = '0;
    for (int i = 0; i < N_REQ; i++) hold[i] = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst.acq",     64'(acq),        64'(0));
    chk("rst.ack",     64'(ack),        64'(0));
    chk("rst.RAMwren", 64'(RAMwren),    64'(0));
    chk("rst.RAMAddr", 64'(RAMAddress), 64'(0));
    chk("rst.RAMDin",  64'(RAMDin),     64'(0));
    chk("rst.Dq",      64'(Dq),         64'(0));
    chk("rst.busy",    64'(busy),       64'(0));
    step("rst");
    step("rst");
    ram_clear = 1'b0;
    rden = '0; wren = '0; Address = '0; Din = '0;
    step("rst");
    rst = 1'b1;
    step("idle");

    // 2. single write by requester 1
    wren[1] = 1'b1;
    Address[1*AW +: AW] = 8'h10;
    Din[1*DW +: DW] = 8'hAB;
    step("wr");
    chk("wr.t1.RAMwren", 64'(RAMwren),    64'(1));
    chk("wr.t1.RAMAddr", 64'(RAMAddress), 64'(8'h10));
    chk("wr.t1.RAMDin",  64'(RAMDin),     64'(8'hAB));
    chk("wr.t1.acq",     64'(acq),        64'(4'b0010));
    step("wr");
    chk("wr.t2.RAMwren", 64'(RAMwren),    64'(0));
    chk("wr.t2.ack",     64'(ack),        64'(4'b0010));
    chk("wr.t2.acq",     64'(acq),        64'(4'b0010));
    wren[1] = 1'b0;
    step("wr");
    chk("wr.t3.acq", 64'(acq), 64'(0));

    // 3. read-back by requester 1
    rden[1] = 1'b1;
    step("rd");
    step("rd");
    chk("rd.t2.ack", 64'(ack), 64'(0));
    step("rd");
    chk("rd.t3.Dq1",   64'(Dq[1*DW +: DW]), 64'(8'hAB));
    chk("rd.t3.ack",   64'(ack),            64'(4'b0010));
    chk("rd.t3.other", 64'(Dq & ~32'h0000_FF00), 64'(0));
    rden[1] = 1'b0;
    step("rd");

    // 4. four-way contention after reset
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < N_REQ; i++) Address[i*AW +: AW] = 8'h10;
    rden = '1;
    step("rr.rst");
    rst = 1'b1;
    for (int k = 0; k < 40 && ack_idx.size() < 5; k++) begin
      step("rr");
      if (ack != '0) begin
        for (int i = 0; i < N_REQ; i++) if (ack[i]) ack_idx.push_back(i);
        ack_cyc.push_back(cyc);
      end
    end
    rden = '0;
    chk("rr.count", 64'(ack_idx.size()), 64'(5));
    exp_order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5 && k < ack_idx.size(); k++)
      chk($sformatf("rr.order%0d", k), 64'(ack_idx[k]), 64'(exp_order[k]));
    for (int k = 1; k < 5 && k < ack_cyc.size(); k++)
      chk($sformatf("rr.gap%0d", k), 64'(ack_cyc[k] - ack_cyc[k-1]), 64'(4));
    drain("rr.drain");

    // 5. rden and wren together on requester 2 is a write
    rden[2] = 1'b1;
    wren[2] = 1'b1;
    Address[2*AW +: AW] = 8'h20;
    Din[2*DW +: DW] = 8'h5C;
    step("rw");
    chk("rw.t1.RAMwren", 64'(RAMwren), 64'(1));
    chk("rw.t1.RAMDin",  64'(RAMDin),  64'(8'h5C));
    chk("rw.t1.acq",     64'(acq),     64'(4'b0100));
    step("rw");
    chk("rw.t2.ack", 64'(ack),             64'(4'b0100));
    chk("rw.t2.Dq2", 64'(Dq[2*DW +: DW]), 64'(8'hAB));
    rden[2] = 1'b0;
    wren[2] = 1'b0;
    step("rw");
    chk("rw.ram", 64'(ram_mem[8'h20]), 64'(8'h5C));

    // 6. reset during WAIT, then held request re-granted
    rden[3] = 1'b1;
    Address[3*AW +: AW] = 8'h20;
    step("rw6");
    step("rw6");
    chk("rw6.wait.busy", 64'(busy), 64'(1));
    rst = 1'b0;
    #1;
    chk("rw6.rst.acq",  64'(acq),  64'(0));
    chk("rw6.rst.ack",  64'(ack),  64'(0));
    chk("rw6.rst.busy", 64'(busy), 64'(0));
    model_reset();
    step("rw6.rst");
    rst = 1'b1;
    step("rw6.rel");
    chk("rw6.rel.acq", 64'(acq), 64'(4'b1000));
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step("rw6.run");
      if (ack != '0) begin
        seen = 1'b1;
        chk("rw6.ack", 64'(ack),             64'(4'b1000));
        chk("rw6.Dq3", 64'(Dq[3*DW +: DW]), 64'(8'h5C));
      end
    end
    chk("rw6.ack_seen", 64'(seen), 64'(1));
    rden[3] = 1'b0;
    drain("rw6.drain");

    // Random traffic, including abandoned requests
    for (int c = 0; c < 800; c++) begin
      step("rnd");
      for (int i = 0; i < N_REQ; i++) begin
        if (hold[i]) begin
          if ((m_active && m_g == i && m_cnt == ack_at()) || $urandom_range(99) < 2) begin
            rden[i] = 1'b0;
            wren[i] = 1'b0;
            hold[i] = 1'b0;
          end
        end else if ($urandom_range(99) < 30) begin
          op = int'($urandom_range(2));
          rden[i] = (op != 1);
          wren[i] = (op != 0);
          Address[i*AW +: AW] = 8'h40 | AW'($urandom_range(15));
          Din[i*DW +: DW] = DW'($urandom);
          hold[i] = 1'b1;
        end
      end
    end
    rden = '0;
    wren = '0;
    drain("rnd.drain");
    step("end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
